// File: rtl/reg_wb_queue_if.sv
// reg_wb_queue_if: bundles the result-input handshake, the register-file write
// port and the decode hazard-lookup signals of the writeback queue.
// The slave modport is the queue's view of the bundle. The master modport is the
// surrounding pipeline's view (execute, register file and decode).
interface reg_wb_queue_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_rd;
    logic [DATA_W-1:0] in_data;
    logic              rf_wen;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_wready;
    logic [ADDR_W-1:0] q_raddr1;
    logic [ADDR_W-1:0] q_raddr2;
    logic              q_hit1;
    logic              q_hit2;
    logic [DATA_W-1:0] q_data1;
    logic [DATA_W-1:0] q_data2;
    logic              empty;

    modport slave (
        input  in_valid, in_rd, in_data, rf_wready, q_raddr1, q_raddr2,
        output in_ready, rf_wen, rf_waddr, rf_wdata, q_hit1, q_hit2,
               q_data1, q_data2, empty
    );

    modport master (
        output in_valid, in_rd, in_data, rf_wready, q_raddr1, q_raddr2,
        input  in_ready, rf_wen, rf_waddr, rf_wdata, q_hit1, q_hit2,
               q_data1, q_data2, empty
    );
endinterface

// File: rtl/reg_wb_queue.sv
// reg_wb_queue: in-order writeback buffer in front of the integer register file
// write port. Completed results are queued and retired one per cycle. Decode can
// look up its two source registers against the pending writes.
// Optional feature macro: WB_BYPASS_EN. When it is defined, q_data1/q_data2 carry
// the youngest pending value for a hit. When it is undefined, they are tied to 0
// and only the hit flags are produced.
module reg_wb_queue #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input logic           clk,
    input logic           rst_n,
    reg_wb_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    // Storage and pointers; the extra pointer MSB distinguishes full from empty
    logic [ADDR_W-1:0] mem_rd_q   [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [PTR_W:0]    wr_ptr_q;
    logic [PTR_W:0]    wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q;
    logic [PTR_W:0]    rd_ptr_d;

    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    logic [PTR_W:0]    count_s;
    logic [PTR_W-1:0]  idx_s;
    logic              valid_s;
    logic              hit1_s;
    logic              hit2_s;
    logic [DATA_W-1:0] data1_s;
    logic [DATA_W-1:0] data2_s;

    assign full_s  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign count_s = wr_ptr_q - rd_ptr_q;

    // x0 results are discarded at the input. They are never stored and never advance the pointer.
    assign push_s  = bus.in_valid && !full_s && (bus.in_rd != {ADDR_W{1'b0}});
    assign pop_s   = !empty_s && bus.rf_wready;

    // Next-state pointer computation
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers; reset empties the queue immediately, dropping pending writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {(PTR_W+1){1'b0}};
            rd_ptr_q <= {(PTR_W+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage, written at the tail on an accepted non-x0 result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_rd_q[i]   <= {ADDR_W{1'b0}};
                mem_data_q[i] <= {DATA_W{1'b0}};
            end
        end else if (push_s) begin
            mem_rd_q[wr_ptr_q[PTR_W-1:0]]   <= bus.in_rd;
            mem_data_q[wr_ptr_q[PTR_W-1:0]] <= bus.in_data;
        end
    end

    // Hazard lookup: scan from oldest to youngest so later matches override earlier ones
    always_comb begin
        hit1_s  = 1'b0;
        hit2_s  = 1'b0;
        data1_s = {DATA_W{1'b0}};
        data2_s = {DATA_W{1'b0}};
        idx_s   = {PTR_W{1'b0}};
        valid_s = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx_s   = rd_ptr_q[PTR_W-1:0] + PTR_W'(k);
            valid_s = ((PTR_W+1)'(k) < count_s);
            if (valid_s && (bus.q_raddr1 != {ADDR_W{1'b0}}) &&
                (mem_rd_q[idx_s] == bus.q_raddr1)) begin
                hit1_s  = 1'b1;
`ifdef WB_BYPASS_EN
                data1_s = mem_data_q[idx_s];
`endif
            end else begin
                hit1_s  = hit1_s;
            end
            if (valid_s && (bus.q_raddr2 != {ADDR_W{1'b0}}) &&
                (mem_rd_q[idx_s] == bus.q_raddr2)) begin
                hit2_s  = 1'b1;
`ifdef WB_BYPASS_EN
                data2_s = mem_data_q[idx_s];
`endif
            end else begin
                hit2_s  = hit2_s;
            end
        end
    end

    // Full blocks input even when a pop happens in the same cycle (no pass-through)
    assign bus.in_ready = !full_s;
    assign bus.empty    = empty_s;
    assign bus.rf_wen   = !empty_s;
    assign bus.rf_waddr = mem_rd_q[rd_ptr_q[PTR_W-1:0]];
    assign bus.rf_wdata = mem_data_q[rd_ptr_q[PTR_W-1:0]];
    assign bus.q_hit1   = hit1_s;
    assign bus.q_hit2   = hit2_s;
`ifdef WB_BYPASS_EN
    assign bus.q_data1  = data1_s;
    assign bus.q_data2  = data2_s;
`else
    assign bus.q_data1  = {DATA_W{1'b0}};
    assign bus.q_data2  = {DATA_W{1'b0}};
`endif

endmodule
